// File: rtl/i2s_sample_feeder_if.sv
// rtl/i2s_sample_feeder_if.sv - producer stream and i2s word/request bundle for the sample feeder
//   s_data/s_valid/s_ready : producer word handshake ({left[31:16], right[15:0]})
//   i2s_req/i2s_sound      : per-frame request pulse from the i2s block and the word it consumes
//   master modport drives producer/i2s side, slave modport is the feeder
interface i2s_sample_feeder_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        i2s_req;
    logic [31:0] i2s_sound;

    modport master (output s_data, output s_valid, output i2s_req,
                    input  s_ready, input  i2s_sound);
    modport slave  (input  s_data, input  s_valid, input  i2s_req,
                    output s_ready, output i2s_sound);
endinterface

// File: rtl/i2s_sample_feeder.sv
// rtl/i2s_sample_feeder.sv - FIFO-buffered scheduler releasing one stereo word per i2s request
//   clkin, rst_n            : clock, asynchronous active-low reset
//   enable                  : low flushes the FIFO and idles the feeder
//   mute                    : emitted words forced to 0, FIFO still drains
//   clr_stats               : clears underrun_cnt (wins over a same-cycle increment)
//   bus (slave)             : producer handshake plus i2s_req/i2s_sound
//   fill, running, underrun, underrun_cnt : occupancy and status
module i2s_sample_feeder #(
    parameter int ADDR_W        = 3,
    parameter int PRIME_LEVEL   = 4,
    parameter int HOLD_ON_UNDER = 0
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                mute,
    input  logic                clr_stats,
    i2s_sample_feeder_if.slave  bus,
    output logic [ADDR_W:0]     fill,
    output logic                running,
    output logic                underrun,
    output logic [15:0]         underrun_cnt
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int FILL_W = ADDR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [31:0]         sound_q, sound_d;
    logic [31:0]         last_q, last_d;
    logic                under_q, under_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [31:0]         mem_q [DEPTH];

    logic full;
    logic s_ready;
    logic push;
    logic pop;

    // s_ready depends only on registered state so the producer never sees a combinational loop
    assign full    = (fill_q == FILL_W'(DEPTH));
    assign s_ready = (state_q != ST_IDLE) && !full;
    assign push    = bus.s_valid && s_ready;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        sound_d  = sound_q;
        last_d   = last_q;
        under_d  = 1'b0;
        cnt_d    = cnt_q;
        pop      = 1'b0;

        if (!enable) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            sound_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_PRIME;
                ST_PRIME: if (bus.i2s_req) sound_d = '0;
                ST_RUN: begin
                    if (bus.i2s_req) begin
                        if (fill_q != '0) begin
                            pop     = 1'b1;
                            sound_d = mute ? '0 : mem_q[rd_ptr_q];
                            last_d  = mem_q[rd_ptr_q];
                        end else begin
                            // Starved: fall back to PRIME so the FIFO refills before resuming
                            under_d = 1'b1;
                            cnt_d   = (cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
                            sound_d = (mute || HOLD_ON_UNDER == 0) ? '0 : last_q;
                            state_d = ST_PRIME;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // At empty the popped slot is not the pushed one: pop is suppressed, so no bypass
            if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            fill_d = fill_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};

            if (state_q == ST_PRIME && fill_d >= FILL_W'(PRIME_LEVEL)) state_d = ST_RUN;
        end

        if (clr_stats) cnt_d = '0;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            sound_q  <= '0;
            last_q   <= '0;
            under_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            sound_q  <= sound_d;
            last_q   <= last_d;
            under_q  <= under_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are meaningful
    always_ff @(posedge clkin) begin
        if (push && enable) mem_q[wr_ptr_q] <= bus.s_data;
    end

    assign bus.s_ready   = s_ready;
    assign bus.i2s_sound = sound_q;
    assign fill          = fill_q;
    assign running       = (state_q == ST_RUN);
    assign underrun      = under_q;
    assign underrun_cnt  = cnt_q;
endmodule

// File: tb/tb_i2s_sample_feeder.sv
// tb/tb_i2s_sample_feeder.sv - scoreboard bench for i2s_sample_feeder
module tb_i2s_sample_feeder;
    localparam int PL   = 4;
    localparam int HOLD = 0;

    logic        clkin = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        mute = 1'b0;
    logic        clr_stats = 1'b0;
    logic [3:0]  fill;
    logic        running;
    logic        underrun;
    logic [15:0] underrun_cnt;

    i2s_sample_feeder_if bus();

    i2s_sample_feeder #(.ADDR_W(3), .PRIME_LEVEL(PL), .HOLD_ON_UNDER(HOLD)) dut (
        .clkin(clkin), .rst_n(rst_n), .enable(enable), .mute(mute), .clr_stats(clr_stats),
        .bus(bus), .fill(fill), .running(running), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 clkin = ~clkin;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl_fifo [$];
    logic [31:0] exp_q [$];
    int          mdl_state = 0;   // 0 idle, 1 prime, 2 run
    logic [15:0] mdl_cnt   = 0;
    logic [31:0] mdl_last  = 0;
    logic        mdl_under = 0;

    function automatic logic [31:0] wv(input int i);
        return 32'hCAFE_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] next_exp();
        if (exp_q.size() == 0) return 32'hxxxx_xxxx;
        return exp_q.pop_front();
    endfunction

    // Drive one cycle of stimulus, advance the reference model, queue expected words on requests
    task automatic tick(input logic v, input logic [31:0] d, input logic r);
        logic        acc;
        logic [31:0] w;
        int          st0;
        bus.s_valid = v; bus.s_data = d; bus.i2s_req = r;
        st0 = mdl_state;
        acc = v && enable && (mdl_state != 0) && (mdl_fifo.size() < 8);
        mdl_under = 1'b0;
        if (!enable) begin
            mdl_fifo.delete();
            mdl_state = 0;
            if (r) exp_q.push_back(32'h0);
        end else begin
            case (st0)
                0: mdl_state = 1;
                1: if (r) exp_q.push_back(32'h0);
                default: if (r) begin
                    if (mdl_fifo.size() > 0) begin
                        w = mdl_fifo.pop_front();
                        mdl_last = w;
                        exp_q.push_back(mute ? 32'h0 : w);
                    end else begin
                        mdl_under = 1'b1;
                        if (mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
                        exp_q.push_back((mute || HOLD == 0) ? 32'h0 : mdl_last);
                        mdl_state = 1;
                    end
                end
            endcase
            if (acc) mdl_fifo.push_back(d);
            if (st0 == 1 && mdl_fifo.size() >= PL) mdl_state = 2;
        end
        if (clr_stats) mdl_cnt = 16'h0;
        @(posedge clkin); #1;
        bus.s_valid = 1'b0; bus.i2s_req = 1'b0;
    endtask

    task automatic test_reset();
        bus.s_valid = 1'b0; bus.s_data = '0; bus.i2s_req = 1'b0;
        repeat (2) @(posedge clkin);
        #1;
        total++; if (fill !== 4'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", fill); end
        total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b want=0", bus.s_ready); end
        total++; if (bus.i2s_sound !== 32'h0) begin bad++; $display("FAIL reset_sound got=%h want=0", bus.i2s_sound); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
        total++; if (underrun_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", underrun_cnt); end
        rst_n = 1'b1;
        tick(1'b0, 32'h0, 1'b0);
        total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL idle_s_ready got=%b want=0", bus.s_ready); end
    endtask

    task automatic test_prime();
        enable = 1'b1;
        tick(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL prime_s_ready[%0d] got=%b want=1", i, bus.s_ready); end
            tick(1'b1, wv(i), 1'b0);
            total++; if (fill !== 4'(i + 1)) begin bad++; $display("FAIL prime_fill[%0d] got=%0d want=%0d", i, fill, i + 1); end
            total++; if (running !== (i >= 3)) begin bad++; $display("FAIL prime_running[%0d] got=%b want=%b", i, running, i >= 3); end
        end
        total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL full_s_ready got=%b want=0", bus.s_ready); end
    endtask

    task automatic test_full_req_push();
        logic [31:0] e;
        tick(1'b1, 32'h1234_5678, 1'b1);   // push blocked at full, pop frees a slot
        e = next_exp();
        total++; if (bus.i2s_sound !== e) begin bad++; $display("FAIL full_pop_sound got=%h want=%h", bus.i2s_sound, e); end
        total++; if (fill !== 4'd7) begin bad++; $display("FAIL full_pop_fill got=%0d want=7", fill); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL full_pop_underrun got=%b want=0", underrun); end
        total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL after_pop_s_ready got=%b want=1", bus.s_ready); end
        tick(1'b1, 32'h1234_5678, 1'b0);
        total++; if (fill !== 4'd8) begin bad++; $display("FAIL refill got=%0d want=8", fill); end
        tick(1'b1, 32'hDEAD_0001, 1'b1);   // blocked word must never appear
        e = next_exp();
        total++; if (bus.i2s_sound !== e) begin bad++; $display("FAIL full_pop2_sound got=%h want=%h", bus.i2s_sound, e); end
        total++; if (fill !== 4'd7) begin bad++; $display("FAIL full_pop2_fill got=%0d want=7", fill); end
    endtask

    task automatic test_mute();
        logic [31:0] e;
        mute = 1'b1;
        tick(1'b0, 32'h0, 1'b1);
        mute = 1'b0;
        e = next_exp();
        total++; if (bus.i2s_sound !== e) begin bad++; $display("FAIL mute_sound got=%h want=%h", bus.i2s_sound, e); end
        total++; if (fill !== 4'd6) begin bad++; $display("FAIL mute_fill got=%0d want=6", fill); end
    endtask

    task automatic test_drain_underrun();
        logic [31:0] e;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 32'h0, 1'b1);
            e = next_exp();
            total++; if (bus.i2s_sound !== e) begin bad++; $display("FAIL drain_sound[%0d] got=%h want=%h", i, bus.i2s_sound, e); end
            total++; if (fill !== 4'(5 - i)) begin bad++; $display("FAIL drain_fill[%0d] got=%0d want=%0d", i, fill, 5 - i); end
        end
        total++; if (running !== 1'b1) begin bad++; $display("FAIL empty_running got=%b want=1", running); end
        tick(1'b1, 32'h5A5A_A5A5, 1'b1);   // underrun with concurrent push: word stored, not emitted
        e = next_exp();
        total++; if (bus.i2s_sound !== e) begin bad++; $display("FAIL under_sound got=%h want=%h", bus.i2s_sound, e); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL under_pulse got=%b want=1", underrun); end
        total++; if (underrun_cnt !== mdl_cnt) begin bad++; $display("FAIL under_cnt got=%0d want=%0d", underrun_cnt, mdl_cnt); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL under_running got=%b want=0", running); end
        total++; if (fill !== 4'd1) begin bad++; $display("FAIL under_fill got=%0d want=1", fill); end
        tick(1'b0, 32'h0, 1'b1);           // request in PRIME: zero word, no pop, no count
        e = next_exp();
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL prime_req_pulse got=%b want=0", underrun); end
        total++; if (bus.i2s_sound !== e) begin bad++; $display("FAIL prime_req_sound got=%h want=%h", bus.i2s_sound, e); end
        total++; if (underrun_cnt !== 16'd1) begin bad++; $display("FAIL prime_req_cnt got=%0d want=1", underrun_cnt); end
        total++; if (fill !== 4'd1) begin bad++; $display("FAIL prime_req_fill got=%0d want=1", fill); end
    endtask

    task automatic test_clr_stats();
        logic [31:0] e;
        for (int i = 0; i < 3; i++) tick(1'b1, wv(16 + i), 1'b0);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL reprime_running got=%b want=1", running); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 32'h0, 1'b1);
            e = next_exp();
            total++; if (bus.i2s_sound !== e) begin bad++; $display("FAIL clr_drain[%0d] got=%h want=%h", i, bus.i2s_sound, e); end
        end
        clr_stats = 1'b1;
        tick(1'b0, 32'h0, 1'b1);
        clr_stats = 1'b0;
        void'(next_exp());
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL clr_pulse got=%b want=1", underrun); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL clr_wins got=%0d want=0", underrun_cnt); end
    endtask

    task automatic test_enable_drop();
        logic [31:0] e;
        for (int i = 0; i < 6; i++) tick(1'b1, wv(32 + i), 1'b0);
        tick(1'b0, 32'h0, 1'b1);
        e = next_exp();
        total++; if (bus.i2s_sound !== e) begin bad++; $display("FAIL pre_drop_sound got=%h want=%h", bus.i2s_sound, e); end
        total++; if (fill !== 4'd5) begin bad++; $display("FAIL pre_drop_fill got=%0d want=5", fill); end
        enable = 1'b0;
        tick(1'b1, wv(40), 1'b1);
        e = next_exp();
        total++; if (bus.i2s_sound !== e) begin bad++; $display("FAIL drop_sound got=%h want=%h", bus.i2s_sound, e); end
        total++; if (fill !== 4'd0) begin bad++; $display("FAIL drop_fill got=%0d want=0", fill); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL drop_running got=%b want=0", running); end
        total++; if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL drop_s_ready got=%b want=0", bus.s_ready); end
    endtask

    initial begin
        test_reset();
        test_prime();
        test_full_req_push();
        test_mute();
        test_drain_underrun();
        test_clr_stats();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
